// File: rtl/instr_queue.sv
// Decoded-instruction FIFO between decode and dispatch, feeding one ROB entry
// plus one reservation-station slot per cycle; a mispredict flush empties it.
package tomasula_types;
   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_MUL    = 3'd2,
      OP_LD     = 3'd3,
      OP_ST     = 3'd4,
      OP_BRANCH = 3'd5
   } op_t;
endpackage

module instr_queue
   import tomasula_types::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  op_t              enq_op,
   input  logic [4:0]       enq_rd,
   input  logic [4:0]       enq_rs1,
   input  logic [4:0]       enq_rs2,
   input  logic [31:0]      enq_imm,
   input  logic [31:0]      enq_pc,
   input  logic             rob_full,
   input  logic             rs_ready,
   output logic             rob_load,
   output logic             rs_load,
   output op_t              instr_type,
   output logic [4:0]       rd,
   output logic [4:0]       st_src,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [31:0]      imm,
   output logic [31:0]      pc,
   output logic [PTR_W:0]   count
);

   typedef struct packed {
      op_t         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
   } entry_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [PTR_W:0]     r_count;

   logic               w_enqFire;
   logic               w_deqFire;
   logic               w_empty;
   entry_t             w_head;

   assign w_empty   = (r_count == '0);
   assign enq_ready = (r_count != FULL_CNT) && !flush;
   assign w_enqFire = enq_valid && enq_ready;
   assign w_deqFire = !w_empty && !rob_full && rs_ready && !flush;
   assign rob_load  = w_deqFire;
   assign rs_load   = w_deqFire;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (w_enqFire && !rst) begin
         r_mem[r_tail] <= '{op: enq_op, rd: enq_rd, rs1: enq_rs1, rs2: enq_rs2,
                            imm: enq_imm, pc: enq_pc};
      end
   end

   // Pointers wrap naturally at DEPTH-1; occupancy alone decides full/empty.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enqFire) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_deqFire) begin
            r_head <= r_head + 1'b1;
         end
         if (w_enqFire && !w_deqFire) begin
            r_count <= r_count + 1'b1;
         end else if (!w_enqFire && w_deqFire) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Stores carry no destination; their data register travels on st_src instead.
   always_comb begin
      w_head     = r_mem[r_head];
      instr_type = OP_ADD;
      rd         = '0;
      st_src     = '0;
      rs1        = '0;
      rs2        = '0;
      imm        = '0;
      pc         = '0;
      if (!w_empty) begin
         instr_type = w_head.op;
         rs1        = w_head.rs1;
         rs2        = w_head.rs2;
         imm        = w_head.imm;
         pc         = w_head.pc;
         if (w_head.op == OP_ST) begin
            st_src = w_head.rs2;
         end else if (w_head.op != OP_BRANCH) begin
            rd = w_head.rd;
         end
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the FIFO.
module tb_instr_queue;
   import tomasula_types::*;

   typedef struct {
      op_t         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
   } item_t;

   logic        clk = 1'b0;
   logic        rst, flush, enq_valid, enq_ready;
   op_t         enq_op;
   logic [4:0]  enq_rd, enq_rs1, enq_rs2;
   logic [31:0] enq_imm, enq_pc;
   logic        rob_full, rs_ready, rob_load, rs_load;
   op_t         instr_type;
   logic [4:0]  rd, st_src, rs1, rs2;
   logic [31:0] imm, pc;
   logic [3:0]  count;

   int          numCompared = 0;
   int          numMismatched = 0;
   item_t       model[$];

   logic        obsLoad, obsReady;
   logic [4:0]  obsRd, obsStSrc;
   logic [31:0] obsPc;
   logic [3:0]  obsCount;
   op_t         obsType;

   instr_queue #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_op(enq_op),
      .enq_rd(enq_rd), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
      .enq_imm(enq_imm), .enq_pc(enq_pc),
      .rob_full(rob_full), .rs_ready(rs_ready),
      .rob_load(rob_load), .rs_load(rs_load), .instr_type(instr_type),
      .rd(rd), .st_src(st_src), .rs1(rs1), .rs2(rs2),
      .imm(imm), .pc(pc), .count(count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare every output with the model, then let the edge happen.
   task automatic applyStimulus(input logic iRst, input logic iFlush, input logic iEnqValid,
                                input op_t iOp, input logic [4:0] iRd, input logic [4:0] iRs1,
                                input logic [4:0] iRs2, input logic [31:0] iImm,
                                input logic [31:0] iPc, input logic iRobFull, input logic iRsReady);
      logic  expReady, expFire;
      item_t h;
      @(negedge clk);
      rst = iRst; flush = iFlush; enq_valid = iEnqValid; enq_op = iOp;
      enq_rd = iRd; enq_rs1 = iRs1; enq_rs2 = iRs2; enq_imm = iImm; enq_pc = iPc;
      rob_full = iRobFull; rs_ready = iRsReady;
      #1;
      expReady = (model.size() != 8) && !iFlush;
      expFire  = (model.size() != 0) && !iRobFull && iRsReady && !iFlush;
      checkOutput("enq_ready", 32'(enq_ready), 32'(expReady));
      checkOutput("rob_load", 32'(rob_load), 32'(expFire));
      checkOutput("rs_load", 32'(rs_load), 32'(expFire));
      checkOutput("count", 32'(count), 32'(model.size()));
      if (model.size() == 0) begin
         checkOutput("instr_type", 32'(instr_type), 32'd0);
         checkOutput("rd", 32'(rd), 32'd0);
         checkOutput("st_src", 32'(st_src), 32'd0);
         checkOutput("rs1", 32'(rs1), 32'd0);
         checkOutput("rs2", 32'(rs2), 32'd0);
         checkOutput("imm", imm, 32'd0);
         checkOutput("pc", pc, 32'd0);
      end else begin
         h = model[0];
         checkOutput("instr_type", 32'(instr_type), 32'(h.op));
         checkOutput("rd", 32'(rd), (h.op == OP_ST || h.op == OP_BRANCH) ? 32'd0 : 32'(h.rd));
         checkOutput("st_src", 32'(st_src), (h.op == OP_ST) ? 32'(h.rs2) : 32'd0);
         checkOutput("rs1", 32'(rs1), 32'(h.rs1));
         checkOutput("rs2", 32'(rs2), 32'(h.rs2));
         checkOutput("imm", imm, h.imm);
         checkOutput("pc", pc, h.pc);
      end
      obsLoad = rob_load; obsReady = enq_ready; obsRd = rd; obsStSrc = st_src;
      obsPc = pc; obsCount = count; obsType = instr_type;
      @(posedge clk);
      if (iRst || iFlush) begin
         model.delete();
      end else begin
         if (expFire) void'(model.pop_front());
         if (iEnqValid && expReady)
            model.push_back('{op: iOp, rd: iRd, rs1: iRs1, rs2: iRs2, imm: iImm, pc: iPc});
      end
   endtask

   task automatic enqOp(input op_t op, input logic [4:0] r, input logic [4:0] s2,
                        input logic [31:0] p, input logic robFull);
      applyStimulus(1'b0, 1'b0, 1'b1, op, r, 5'd1, s2, 32'h10, p, robFull, 1'b1);
   endtask

   task automatic idle(input logic robFull);
      applyStimulus(1'b0, 1'b0, 1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, robFull, 1'b1);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_op = OP_ADD;
      enq_rd = '0; enq_rs1 = '0; enq_rs2 = '0; enq_imm = '0; enq_pc = '0;
      rob_full = 1'b0; rs_ready = 1'b1;
      repeat (2) @(posedge clk);

      idle(1'b0);
      checkOutput("reset_count", 32'(obsCount), 32'd0);
      checkOutput("reset_ready", 32'(obsReady), 32'd1);
      checkOutput("reset_load", 32'(obsLoad), 32'd0);

      enqOp(OP_ADD, 5'd5, 5'd2, 32'h100, 1'b0);
      idle(1'b0);
      checkOutput("add_load", 32'(obsLoad), 32'd1);
      checkOutput("add_rd", 32'(obsRd), 32'd5);
      checkOutput("add_count", 32'(obsCount), 32'd1);
      idle(1'b0);
      checkOutput("add_drained_count", 32'(obsCount), 32'd0);
      checkOutput("add_drained_rd", 32'(obsRd), 32'd0);

      enqOp(OP_ST, 5'd3, 5'd7, 32'h104, 1'b0);
      idle(1'b0);
      checkOutput("st_type", 32'(obsType), 32'(OP_ST));
      checkOutput("st_rd", 32'(obsRd), 32'd0);
      checkOutput("st_src", 32'(obsStSrc), 32'd7);
      idle(1'b0);

      for (int i = 0; i < 8; i++) enqOp(OP_SUB, 5'(i + 1), 5'd4, 32'h1000 + 32'(4 * i), 1'b1);
      enqOp(OP_LD, 5'd9, 5'd4, 32'h2000, 1'b1);
      checkOutput("full_count", 32'(obsCount), 32'd8);
      checkOutput("full_ready", 32'(obsReady), 32'd0);
      checkOutput("full_load", 32'(obsLoad), 32'd0);
      enqOp(OP_LD, 5'd9, 5'd4, 32'h2000, 1'b0);
      checkOutput("full_pop_ready", 32'(obsReady), 32'd0);
      checkOutput("full_pop_load", 32'(obsLoad), 32'd1);
      enqOp(OP_LD, 5'd9, 5'd4, 32'h2000, 1'b1);
      checkOutput("after_pop_count", 32'(obsCount), 32'd7);
      checkOutput("after_pop_ready", 32'(obsReady), 32'd1);
      idle(1'b1);
      checkOutput("refill_count", 32'(obsCount), 32'd8);
      for (int i = 0; i < 8; i++) begin
         idle(1'b0);
         checkOutput("drain_pc", obsPc, (i < 7) ? 32'h1004 + 32'(4 * i) : 32'h2000);
      end
      idle(1'b0);
      checkOutput("drain_empty", 32'(obsCount), 32'd0);

      for (int i = 0; i < 4; i++) enqOp(OP_MUL, 5'd6, 5'd1, 32'h3000 + 32'(4 * i), 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, OP_ADD, 5'd8, 5'd1, 5'd1, 32'd0, 32'h4000, 1'b0, 1'b1);
      checkOutput("flush_load", 32'(obsLoad), 32'd0);
      checkOutput("flush_count_before", 32'(obsCount), 32'd4);
      idle(1'b1);
      checkOutput("flush_count_after", 32'(obsCount), 32'd0);

      for (int i = 0; i < 5; i++) enqOp(OP_BRANCH, 5'd2, 5'd3, 32'h5000 + 32'(4 * i), 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, OP_ADD, 5'd8, 5'd1, 5'd1, 32'd0, 32'h6000, 1'b1, 1'b1);
      checkOutput("rst_count_before", 32'(obsCount), 32'd5);
      idle(1'b0);
      checkOutput("rst_count_after", 32'(obsCount), 32'd0);
      checkOutput("rst_pc_after", obsPc, 32'd0);
      enqOp(OP_ADD, 5'd9, 5'd2, 32'h7000, 1'b1);
      idle(1'b0);
      checkOutput("post_rst_load", 32'(obsLoad), 32'd1);
      checkOutput("post_rst_pc", obsPc, 32'h7000);
      checkOutput("post_rst_rd", 32'(obsRd), 32'd9);

      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(99) < 1, $urandom_range(99) < 3,
                       $urandom_range(99) < 60, op_t'($urandom_range(5)),
                       5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
                       $urandom_range(99) < 35, $urandom_range(99) < 80);
      end
      idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
